// File: rtl/idecode_fwd.sv
// Instruction decode stage: register-file read with EX/MEM/WB operand forwarding,
// load-use and partial-write hazard detection, and stall/flush handling.
module idecode_fwd #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IR_W   = 64,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned BANK_W = 4,
    localparam int unsigned RA_W  = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IR_W-1:0]   ir_i,
    input  logic [31:0]       pc_i,
    input  logic              valid_i,
    input  logic [BANK_W-1:0] bank_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [1:0]        wb_we_i,
    input  logic [RA_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [1:0]        ex_we_i,
    input  logic [RA_W-1:0]   ex_addr_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic              ex_load_i,
    input  logic [1:0]        mem_we_i,
    input  logic [RA_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [IR_W-1:0]   ir_o,
    output logic [31:0]       pc_o,
    output logic              valid_o,
    output logic [BANK_W-1:0] bank_o,
    output logic [1:0]        reg_write_o,
    output logic [RA_W-1:0]   dest_o,
    output logic              load_o,
    output logic [DATA_W-1:0] op1_o,
    output logic [DATA_W-1:0] op2_o,
    output logic              stall_o
);

    localparam int unsigned HALF_W = DATA_W / 2;

    localparam logic [3:0] T_CMP   = 4'h3;
    localparam logic [3:0] T_MOV   = 4'h4;
    localparam logic [3:0] T_INTU  = 4'h5;
    localparam logic [3:0] T_INT   = 4'h6;
    localparam logic [3:0] T_ALU   = 4'h9;
    localparam logic [3:0] T_LOAD  = 4'ha;
    localparam logic [3:0] T_STORE = 4'hb;
    localparam logic [3:0] T_LDI   = 4'he;

    logic [3:0]        ir_type;
    logic [1:0]        ir_op_lo;
    logic [RA_W-1:0]   ir_ra;
    logic [RA_W-1:0]   ir_rb;
    logic [RA_W-1:0]   ir_rc;

    logic [RA_W-1:0]   rs1_c;
    logic [RA_W-1:0]   rs2_c;
    logic [1:0]        dec_we_c;
    logic              dec_load_c;
    logic [DATA_W-1:0] op1_c;
    logic [DATA_W-1:0] op2_c;
    logic              hazard_c;

    logic [DATA_W-1:0] regs [NREGS];

    assign ir_type  = ir_i[31:28];
    assign ir_op_lo = ir_i[25:24];
    assign ir_ra    = ir_i[20 +: RA_W];
    assign ir_rb    = ir_i[16 +: RA_W];
    assign ir_rc    = ir_i[12 +: RA_W];

    function automatic logic hits(input logic [1:0] we, input logic [RA_W-1:0] addr,
                                  input logic [RA_W-1:0] src);
        return (we != 2'b00) && (addr == src);
    endfunction

    // Priority: full EX write, full MEM write, then WB halves merged over the register file.
    function automatic logic [DATA_W-1:0] resolve(input logic [RA_W-1:0] src);
        logic [DATA_W-1:0] val;
        val = regs[src];
        if (wb_we_i[0] && (wb_addr_i == src)) val[HALF_W-1:0] = wb_data_i[HALF_W-1:0];
        if (wb_we_i[1] && (wb_addr_i == src)) val[DATA_W-1:HALF_W] = wb_data_i[DATA_W-1:HALF_W];
        if (hits(mem_we_i, mem_addr_i, src) && (mem_we_i == 2'b11)) val = mem_data_i;
        if (hits(ex_we_i, ex_addr_i, src) && (ex_we_i == 2'b11)) val = ex_data_i;
        return val;
    endfunction

    // A source cannot be forwarded yet: pending load in EX or a half-width write in flight.
    function automatic logic src_hazard(input logic [RA_W-1:0] src);
        return (hits(ex_we_i, ex_addr_i, src) && (ex_load_i || (ex_we_i != 2'b11))) ||
               (hits(mem_we_i, mem_addr_i, src) && (mem_we_i != 2'b11));
    endfunction

    always_comb begin
        rs1_c      = ir_rb;
        rs2_c      = ir_rc;
        dec_we_c   = 2'b00;
        dec_load_c = (ir_type == T_LOAD);
        case (ir_type)
            T_INTU: begin
                rs1_c = ir_rb;
                rs2_c = ir_rb;
            end
            T_CMP, T_STORE, T_LOAD: begin
                rs1_c = ir_ra;
                rs2_c = ir_rb;
            end
            default: ;
        endcase
        case (ir_type)
            T_INTU, T_INT, T_LDI, T_LOAD, T_ALU: dec_we_c = 2'b11;
            T_MOV:                               dec_we_c = ir_op_lo;
            default:                             dec_we_c = 2'b00;
        endcase
    end

    always_comb begin
        op1_c    = resolve(rs1_c);
        op2_c    = resolve(rs2_c);
        hazard_c = valid_i && (src_hazard(rs1_c) || src_hazard(rs2_c));
    end

    assign stall_o = stall_i | (hazard_c & ~flush_i);

    // Register file: per-half synchronous write, keeps writing while the stage stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wb_we_i[0]) regs[wb_addr_i][HALF_W-1:0] <= wb_data_i[HALF_W-1:0];
            if (wb_we_i[1]) regs[wb_addr_i][DATA_W-1:HALF_W] <= wb_data_i[DATA_W-1:HALF_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_o        <= '0;
            pc_o        <= '0;
            valid_o     <= 1'b0;
            bank_o      <= '0;
            reg_write_o <= 2'b00;
            dest_o      <= '0;
            load_o      <= 1'b0;
            op1_o       <= '0;
            op2_o       <= '0;
        end else if (flush_i) begin
            valid_o     <= 1'b0;
            reg_write_o <= 2'b00;
            load_o      <= 1'b0;
        end else if (!stall_i) begin
            if (hazard_c) begin
                valid_o     <= 1'b0;
                reg_write_o <= 2'b00;
                load_o      <= 1'b0;
            end else begin
                ir_o        <= ir_i;
                pc_o        <= pc_i;
                valid_o     <= valid_i;
                bank_o      <= bank_i;
                reg_write_o <= valid_i ? dec_we_c : 2'b00;
                dest_o      <= ir_ra;
                load_o      <= valid_i & dec_load_c;
                op1_o       <= op1_c;
                op2_o       <= op2_c;
            end
        end
    end

endmodule

// File: doc/idecode_fwd.md
IDECODE_FWD -- requirements
Module: idecode_fwd

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register/operand width (even, >=8).
REQ-002 SHALL have parameter IR_W, default 64, meaning instruction word width; fields use bits [31:12] as in bexkat1Def.
REQ-003 SHALL have parameter NREGS, default 16, meaning register count; RA_W=$clog2(NREGS), and register fields use the low RA_W bits of each 4-bit field.
REQ-004 SHALL have parameter BANK_W, default 4, meaning bank tag width.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk_i (input, 1, clock) and rst_i (input, 1, reset).
REQ-006 SHALL have these pipeline inputs: ir_i (IR_W), pc_i (32), valid_i (1), bank_i (BANK_W), stall_i (1, downstream hold) and flush_i (1, kill instruction in decode).
REQ-007 SHALL have these writeback inputs: wb_we_i (2; bit0 writes the low half, bit1 the high half), wb_addr_i (RA_W) and wb_data_i (DATA_W).
REQ-008 SHALL have these EX-forward inputs: ex_we_i (2), ex_addr_i (RA_W), ex_data_i (DATA_W) and ex_load_i (1, EX result not yet available).
REQ-009 SHALL have these MEM-forward inputs: mem_we_i (2), mem_addr_i (RA_W) and mem_data_i (DATA_W).
REQ-010 SHALL have these outputs: ir_o (IR_W), pc_o (32), valid_o (1), bank_o (BANK_W), reg_write_o (2), dest_o (RA_W), load_o (1), op1_o (DATA_W), op2_o (DATA_W) and stall_o (1, hold fetch).

Function
REQ-011 SHALL select read addresses by ir_type: T_INTU gives rs1=rs2=rb; T_CMP/T_STORE/T_LOAD give rs1=ra, rs2=rb; all other types give rs1=rb, rs2=rc.
REQ-012 SHALL decode the write enable as follows: T_INTU/T_INT/T_LDI/T_LOAD/T_ALU give 2'b11; T_MOV gives ir_op[1:0]; all other types give 2'b00.
REQ-013 SHALL decode dest as ir_ra and load as (ir_type==T_LOAD).
REQ-014 SHALL contain an internal NREGS x DATA_W register file with synchronous write; each set bit of wb_we_i writes the corresponding half of wb_data_i at wb_addr_i.
REQ-015 SHALL resolve each operand combinationally, highest priority first: EX match with we==11; MEM match with we==11; WB match (per half, half-merged over the register file); register file.
REQ-016 SHALL define "match" as nonzero we and equal address.
REQ-017 SHALL assert stall_o (hazard) whenever valid_i=1 and either source matches EX with ex_load_i=1, or matches EX/MEM with we not 11 (partial write).
REQ-018 SHALL treat both sources as used for hazard purposes, including a duplicate rb.
REQ-019 SHALL, on a hazard with stall_i=0, register a bubble (valid_o=0, reg_write_o=0, load_o=0) and leave ir_o/pc_o/bank_o/op values don't-care.
REQ-020 SHALL expect upstream to hold ir_i/pc_i while stall_o=1.
REQ-021 SHALL assert stall_o whenever stall_i=1 (combined with the hazard).
REQ-022 SHALL hold all registered outputs unchanged while stall_i=1 and flush_i=0; writeback still occurs.
REQ-023 SHALL, when flush_i=1, set valid_o=0, reg_write_o=0 and load_o=0 next cycle regardless of stall_i (flush has priority), with no stall_o from hazard.
REQ-024 SHALL, in the normal case (no stall, no flush, no hazard), register ir_i, pc_i, bank_i, valid_i, the resolved operands and the decodes, giving one-cycle latency.
REQ-025 SHALL force reg_write_o=0 and load_o=0 when valid_i=0.
REQ-026 SHALL handle simultaneous WB and read of the same register by returning the new data (write-through).

Reset
REQ-027 SHALL, on rst_i=1 at a clock edge, clear ir_o, pc_o, valid_o, bank_o, reg_write_o, dest_o, load_o, op1_o and op2_o to zero.
REQ-028 SHALL, on reset, clear every register-file entry to zero.
REQ-029 SHALL drive stall_o combinationally and derive it only from the current inputs.
REQ-030 SHALL make reset override stall_i and flush_i.

Verification
REQ-031 Writeback then read: WB r3=0x12345678 (we=11), then T_ALU rb=3 -> next cycle op1_o=0x12345678, reg_write_o=11.
REQ-032 Forward priority: EX r5=0xAAAA0000 and MEM r5=0x5555FFFF both we=11, T_CMP ra=5 -> op1_o=0xAAAA0000.
REQ-033 Load-use: ex_load_i=1, ex_addr=2, T_ALU rc=2 -> stall_o=1, valid_o=0 next cycle; ex_load_i deasserted with MEM forwarding 0xDEAD -> op2_o=0xDEAD, valid_o=1.
REQ-034 Partial write: WB we=01 r4 data=0x0000BEEF over r4=0x11112222, simultaneous read -> operand 0x1111BEEF; MEM we=10 r4 match -> stall_o=1.
REQ-035 Stall/flush: stall_i=1 for 3 cycles -> outputs frozen; flush_i with stall_i=1 -> valid_o=0 next cycle.
REQ-036 Reset mid-operation: rst_i during stall_i=1 -> all outputs and registers read 0 next cycle.
